// File: rtl/tt_uart_pkg.sv
// Shared UART definitions for the sum_uart_tx serial stage: the frame FSM
// state encoding, the data byte width and the idle level of the serial line.
package tt_uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage : tt_uart_pkg

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter for the UART transmitter.
// Ports:
//   clk      - design clock
//   rst_n    - asynchronous active-low reset
//   clear    - force the counter back to 0 (state change / idle)
//   bit_done - high on the last cycle of a bit period
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Count up, wrapping at the end of each bit period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_bit_timer

// File: rtl/sum_uart_tx.sv
// UART transmitter for the adder sum: accepts a byte over valid/ready and
// sends it as an 8N1 frame (optionally with an even-parity bit), LSB first.
// Ports:
//   clk       - design clock
//   rst_n     - asynchronous active-low reset
//   ena       - design enable; gates acceptance of new bytes only
//   data_in   - byte to transmit
//   valid_in  - data_in is valid
//   ready_out - byte accepted this cycle when valid_in is high (combinational)
//   tx        - serial line, idle high (registered)
//   busy      - a frame is in progress (registered)
module sum_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;
    logic                 timer_clear;
    logic                 transfer;

    assign ready_out   = (state_q == IDLE) && ena;
    assign transfer    = valid_in && ready_out;
    // Hold the timer at zero while idle and restart it on every state change.
    assign timer_clear = (state_q == IDLE) || (state_d != state_q);
    assign tx          = tx_q;
    assign busy        = busy_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (transfer) state_d = START;
            START:  if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done && (idx_q == 3'(DATA_BITS - 1))) begin
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP:   if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic. Outputs are decoded from the next state so
    // the registered tx/busy line up with the state register.
    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        tx_d    = IDLE_LEVEL;
        busy_d  = (state_d != IDLE);

        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    shift_d = data_in;
                    par_d   = ^data_in;
                end
            end
            START: idx_d = '0;
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: ;
        endcase

        unique case (state_d)
            START:   tx_d = ~IDLE_LEVEL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule : sum_uart_tx

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx: one instance without parity, one with
// even parity, both at 4 clocks per bit.
module tb_sum_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] data_in;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        bit          inst;
        int          nbits;
        logic [10:0] expv;   // bit i = line level during frame bit i (start first)
        string       name;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    sum_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .data_in  (data_in),
        .valid_in (valid0),
        .ready_out(ready0),
        .tx       (tx0),
        .busy     (busy0)
    );

    sum_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .data_in  (data_in),
        .valid_in (valid1),
        .ready_out(ready1),
        .tx       (tx1),
        .busy     (busy1)
    );

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Present a byte and return just after the transfer edge; valid stays up.
    task automatic start(input bit inst, input logic [7:0] d);
        @(negedge clk);
        data_in = d;
        if (inst) valid1 = 1'b1; else valid0 = 1'b1;
        chk("ready before transfer", inst ? ready1 : ready0, 1'b1);
        @(posedge clk);
        #1;
        data_in = ~d;   // must not disturb the latched byte
    endtask

    // Sample every cycle of a frame that started at the previous edge, then
    // the single idle cycle that follows it.
    task automatic check_frame(input bit inst, input int nbits, input logic [10:0] expv,
                               input string name);
        for (int i = 0; i < nbits; i++) begin
            int   bad;
            logic got_tx, got_busy;
            bad      = 0;
            got_tx   = expv[i];
            got_busy = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if ((inst ? tx1 : tx0) !== expv[i] || (inst ? busy1 : busy0) !== 1'b1) begin
                    bad++;
                    got_tx   = inst ? tx1 : tx0;
                    got_busy = inst ? busy1 : busy0;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s bit%0d: tx %b busy %b, expected tx %b busy 1",
                         name, i, got_tx, got_busy, expv[i]);
            end
        end
        @(negedge clk);
        chk({name, " idle tx"},    inst ? tx1 : tx0,       1'b1);
        chk({name, " idle busy"},  inst ? busy1 : busy0,   1'b0);
        chk({name, " idle ready"}, inst ? ready1 : ready0, ena);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 10, 11'b00_1101001010, "A5 np"};
        vecs[1] = '{8'h07, 1'b1, 11, 11'b11000001110,   "07 par"};
        vecs[2] = '{8'hA5, 1'b1, 11, 11'b10101001010,   "A5 par"};
        vecs[3] = '{8'h00, 1'b0, 10, 11'b00_1000000000, "00 np"};
        vecs[4] = '{8'hFF, 1'b1, 11, 11'b10111111110,   "FF par"};
        vecs[5] = '{8'h80, 1'b0, 10, 11'b00_1100000000, "80 np"};
        vecs[6] = '{8'h55, 1'b1, 11, 11'b10010101010,   "55 par"};

        rst_n   = 1'b0;
        ena     = 1'b1;
        data_in = 8'h00;
        valid0  = 1'b0;
        valid1  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset tx0",    tx0,    1'b1);
        chk("reset busy0",  busy0,  1'b0);
        chk("reset ready0", ready0, 1'b1);
        chk("reset tx1",    tx1,    1'b1);
        chk("reset busy1",  busy1,  1'b0);
        ena = 1'b0;
        #1;
        chk("ready follows ena", ready0, 1'b0);
        ena = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Gating: ena low blocks acceptance.
        @(negedge clk);
        ena    = 1'b0;
        valid0 = 1'b1;
        data_in = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("gated tx", tx0, 1'b1);
            chk("gated busy", busy0, 1'b0);
        end
        valid0 = 1'b0;
        ena    = 1'b1;

        // Table-driven frames.
        foreach (vecs[v]) begin
            start(vecs[v].inst, vecs[v].data);
            valid0 = 1'b0;
            valid1 = 1'b0;
            check_frame(vecs[v].inst, vecs[v].nbits, vecs[v].expv, vecs[v].name);
        end

        // Back-to-back with valid held: 0x3C then 0xC3 (data_in flips after transfer).
        start(1'b0, 8'h3C);
        check_frame(1'b0, 10, 11'b00_1001111000, "b2b 3C");
        check_frame(1'b0, 10, 11'b00_1110000110, "b2b C3");
        valid0 = 1'b0;

        // Drop ena mid-frame: frame completes, next waits for ena.
        start(1'b0, 8'h3C);
        fork
            check_frame(1'b0, 10, 11'b00_1001111000, "ena drop 3C");
            begin
                repeat (8) @(negedge clk);
                ena = 1'b0;
            end
        join
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ena low hold tx", tx0, 1'b1);
            chk("ena low hold busy", busy0, 1'b0);
        end
        ena = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        check_frame(1'b0, 10, 11'b00_1110000110, "ena restore C3");

        // Asynchronous reset during DATA.
        start(1'b0, 8'hF0);
        valid0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy in DATA", busy0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset tx", tx0, 1'b1);
        chk("async reset busy", busy0, 1'b0);
        chk("async reset ready", ready0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        start(1'b0, 8'h55);
        valid0 = 1'b0;
        check_frame(1'b0, 10, 11'b00_1010101010, "post reset 55");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule : tb_sum_uart_tx
